// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder
//   Decodes a snapshot of DIGITS active-low 7-segment patterns back into a
//   hex word. One digit is decoded per clock. Any pattern outside the 16-glyph
//   set is flagged. The result leaves through a valid/ready handshake.
//
//   Optional build macro: SEG7_DEC_BLANK_EN
//     When defined, the all-off pattern 1111111 is legal. It decodes to
//     nibble 0 and sets blank_mask[idx].
//     When undefined, that pattern is invalid and blank_mask is tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request a decode of seg_in (accepted only when busy=0)
//   seg_in     in   7*DIGITS packed patterns, digit k at [7k+6:7k], bit6=a .. bit0=g
//   busy       out  high from start acceptance until the result handshake completes
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   value      out  decoded word, digit k at nibble [4k+3:4k]
//   err        out  at least one digit held an invalid pattern
//   err_digit  out  index of the lowest-numbered invalid digit (0 if err=0)
//   blank_mask out  per-digit blank flag (optional feature)
module seg7_pattern_decoder #(
  parameter int DIGITS = 8,
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7*DIGITS-1:0]   seg_in,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   value,
  output logic                  err,
  output logic [IDX_W-1:0]      err_digit,
  output logic [DIGITS-1:0]     blank_mask
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state;
  logic [7*DIGITS-1:0] snap;
  logic [IDX_W-1:0]    idx;
  logic [6:0]          cur_seg;

  assign cur_seg = snap[7*idx +: 7];

  // Nibble for a pattern. Unknown and blank patterns map to 0.
  function automatic logic [3:0] seg_nibble(input logic [6:0] seg);
    case (seg)
      7'b1001111: seg_nibble = 4'h1;
      7'b0010010: seg_nibble = 4'h2;
      7'b0000110: seg_nibble = 4'h3;
      7'b1001100: seg_nibble = 4'h4;
      7'b0100100: seg_nibble = 4'h5;
      7'b0100000: seg_nibble = 4'h6;
      7'b0001111: seg_nibble = 4'h7;
      7'b0000000: seg_nibble = 4'h8;
      7'b0001100: seg_nibble = 4'h9;
      7'b0001000: seg_nibble = 4'hA;
      7'b1100000: seg_nibble = 4'hB;
      7'b0110001: seg_nibble = 4'hC;
      7'b1000010: seg_nibble = 4'hD;
      7'b0110000: seg_nibble = 4'hE;
      7'b0111000: seg_nibble = 4'hF;
      default:    seg_nibble = 4'h0;
    endcase
  endfunction

  function automatic logic seg_legal(input logic [6:0] seg);
    case (seg)
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000: seg_legal = 1'b1;
`ifdef SEG7_DEC_BLANK_EN
      7'b1111111:                                     seg_legal = 1'b1;
`endif
      default:                                        seg_legal = 1'b0;
    endcase
  endfunction

`ifdef SEG7_DEC_BLANK_EN
  function automatic logic seg_blank(input logic [6:0] seg);
    seg_blank = (seg == 7'b1111111);
  endfunction
`else
  assign blank_mask = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      value     <= '0;
      err       <= 1'b0;
      err_digit <= '0;
      idx       <= '0;
`ifdef SEG7_DEC_BLANK_EN
      blank_mask <= '0;
`endif
    end else begin
      case (state)
        // IDLE: capture the input word so later seg_in changes are ignored
        IDLE: begin
          if (start) begin
            snap      <= seg_in;
            value     <= '0;
            err       <= 1'b0;
            err_digit <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
`ifdef SEG7_DEC_BLANK_EN
            blank_mask <= '0;
`endif
          end
        end
        // SCAN: one digit per cycle; err_digit latches only the first bad digit
        SCAN: begin
          value[4*idx +: 4] <= seg_nibble(cur_seg);
          if (!seg_legal(cur_seg)) begin
            err <= 1'b1;
            if (!err) err_digit <= idx;
          end
`ifdef SEG7_DEC_BLANK_EN
          if (seg_blank(cur_seg)) blank_mask[idx] <= 1'b1;
`endif
          if (idx == IDX_W'(DIGITS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // DONE: hold the result until the consumer takes it
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Testbench for seg7_pattern_decoder (DIGITS = 8).
// Directed cases plus randomized pattern words checked against a table-lookup
// reference model.
module tb_seg7_pattern_decoder;

  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [55:0] seg_in;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] value;
  logic        err;
  logic [2:0]  err_digit;
  logic [7:0]  blank_mask;

  int n_checks = 0;
  int n_errors = 0;

  // glyph table: index = hex digit, entry = active-low abcdefg pattern
  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

`ifdef SEG7_DEC_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  seg7_pattern_decoder #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .seg_in(seg_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .value(value), .err(err),
    .err_digit(err_digit), .blank_mask(blank_mask));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] enc(input logic [31:0] hex);
    logic [55:0] s;
    for (int k = 0; k < DIGITS; k++) s[7*k +: 7] = pat[hex[4*k +: 4]];
    return s;
  endfunction

  // Reference: search each digit in the glyph table
  function automatic void model(input logic [55:0] s, output logic [31:0] v,
                                output logic e, output logic [2:0] ed,
                                output logic [7:0] bm);
    v = '0; e = 1'b0; ed = '0; bm = '0;
    for (int k = 0; k < DIGITS; k++) begin
      logic [6:0] p;
      bit found;
      p = s[7*k +: 7];
      found = 1'b0;
      for (int h = 0; h < 16; h++)
        if (pat[h] == p) begin v[4*k +: 4] = 4'(h); found = 1'b1; end
      if (!found) begin
        if (BLANK_EN && p == 7'h7F) bm[k] = 1'b1;
        else begin
          if (!e) ed = 3'(k);
          e = 1'b1;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Full transaction, called at #1 after an edge while the DUT is idle
  task automatic do_decode(input string tag, input logic [55:0] s, input int stall,
                           input bit change_seg, input bit extra_starts);
    logic [31:0] ev; logic ee; logic [2:0] eed; logic [7:0] ebm;
    int cnt;
    model(s, ev, ee, eed, ebm);
    seg_in = s; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    if (change_seg) seg_in = {$urandom, $urandom};
    chk({tag, " busy_after_start"}, busy, 1);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      start = (extra_starts && cnt == 3);
      step();
      cnt++;
    end
    start = 1'b0;
    chk({tag, " latency"}, cnt, DIGITS + 1);
    for (int i = 0; i < stall; i++) begin
      chk({tag, " stall_valid"}, out_valid, 1);
      chk({tag, " stall_value"}, value, ev);
      chk({tag, " stall_err"}, err, ee);
      step();
    end
    chk({tag, " valid"}, out_valid, 1);
    chk({tag, " busy_done"}, busy, 1);
    chk({tag, " value"}, value, ev);
    chk({tag, " err"}, err, ee);
    chk({tag, " err_digit"}, err_digit, eed);
    chk({tag, " blank_mask"}, blank_mask, ebm);
    out_ready = 1'b1; start = extra_starts;
    step();
    out_ready = 1'b0; start = 1'b0;
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_valid"}, out_valid, 0);
    chk({tag, " held_value"}, value, ev);
    step();
    chk({tag, " no_second_result"}, busy, 0);
  endtask

  initial begin
    logic [55:0] s;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; seg_in = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_value", value, 0);
    chk("rst_err", err, 0);
    chk("rst_err_digit", err_digit, 0);
    chk("rst_blank", blank_mask, 0);

    do_decode("hex12345678", enc(32'h12345678), 0, 1'b0, 1'b0);
    do_decode("deadbeef_stall", enc(32'hDEADBEEF), 5, 1'b1, 1'b0);

    s = enc(32'h0);
    s[7*2 +: 7] = 7'b1010101;
    s[7*5 +: 7] = 7'b1110000;
    do_decode("two_invalid", s, 0, 1'b0, 1'b0);

    do_decode("ignored_starts", enc(32'hA5C3_0F96), 1, 1'b0, 1'b1);

    // reset while scanning digit 4
    seg_in = enc(32'h87654321); start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midscan_rst_busy", busy, 0);
    chk("midscan_rst_valid", out_valid, 0);
    chk("midscan_rst_value", value, 0);
    do_decode("after_rst", enc(32'h0000000F), 0, 1'b0, 1'b0);

    s = enc(32'h11111111);
    s[7*3 +: 7] = 7'b1111111;
    do_decode("blank_digit3", s, 0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < DIGITS; k++) begin
        case ($urandom_range(0, 7))
          0: s[7*k +: 7] = 7'($urandom);
          1: s[7*k +: 7] = 7'h7F;
          default: s[7*k +: 7] = pat[$urandom_range(0, 15)];
        endcase
      end
      do_decode("random", s, $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
